// File: rtl/decoder_4_16_pkg.sv
// decoder_4_16_pkg: shared widths and the index-to-one-hot decode function
package decoder_4_16_pkg;
    localparam int SEL_W = 16;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(SEL_W);
    typedef struct packed {
        logic             bad;
        logic             none;
        logic [SEL_W-1:0] sel;
    } dec_t;
    function automatic dec_t decode(input logic [IDX_W-1:0] idx);
        return '{bad: idx > IDX_NONE, none: idx == IDX_NONE,
                 sel: idx < IDX_NONE ? SEL_W'(1) << idx[IDX_W-2:0] : '0};
    endfunction
endpackage

// File: rtl/decoder_4_16_if.sv
// decoder_4_16_if: index input, one-hot output and error signals of the decoder
interface decoder_4_16_if #(
    parameter int SEL_W = decoder_4_16_pkg::SEL_W,
    parameter int IDX_W = decoder_4_16_pkg::IDX_W
);
    logic [IDX_W-1:0] in_idx;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] out_select;
    logic             out_none;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [IDX_W-1:0] err_idx;
    logic             err_clr;
    modport master (output in_idx, in_valid, out_ready, err_clr,
                    input  in_ready, out_select, out_none, out_valid, err, err_idx);
    modport slave  (input  in_idx, in_valid, out_ready, err_clr,
                    output in_ready, out_select, out_none, out_valid, err, err_idx);
endinterface

// File: rtl/decoder_4_16_skid_buf_2.sv
// skid_buf_2: two-entry valid/ready skid buffer, output register O backed by skid register S
module skid_buf_2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);
    logic [W-1:0] o_q, o_d, s_q, s_d;
    logic         o_v_q, o_v_d, s_v_q, s_v_d;
    logic         push, pop, o_load, s_load;
    assign in_ready_o  = !s_v_q;
    assign out_data_o  = o_q;
    assign out_valid_o = o_v_q;
    always_comb begin
        pop    = o_v_q && out_ready_i;
        push   = in_valid_i && !s_v_q;
        o_load = push && (!o_v_q || pop);
        s_load = push && o_v_q && !pop;
        o_d    = (s_v_q && pop) ? s_q : o_load ? in_data_i : o_q;
        o_v_d  = pop ? (s_v_q || push) : (o_v_q || push);
        s_d    = s_load ? in_data_i : s_q;
        s_v_d  = s_v_q ? !pop : s_load;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            o_v_q <= 1'b0;
            s_q   <= '0;
            s_v_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            o_v_q <= o_v_d;
            s_q   <= s_d;
            s_v_q <= s_v_d;
        end
    end
endmodule

// File: rtl/decoder_4_16.sv
// decoder_4_16: registered index-to-one-hot decoder with skid buffering and sticky range error
module decoder_4_16 #(
    parameter int SEL_W = decoder_4_16_pkg::SEL_W,
    parameter int IDX_W = decoder_4_16_pkg::IDX_W
) (
    input logic           clk,
    input logic           rst_n,
    decoder_4_16_if.slave bus
);
    decoder_4_16_pkg::dec_t d;
    logic                   acc_bad, err_q, err_d;
    logic [IDX_W-1:0]       err_idx_q, err_idx_d;
    assign d = decoder_4_16_pkg::decode(bus.in_idx);
    // out-of-range indices are accepted but never reach the buffer
    skid_buf_2 #(.W(SEL_W + 1)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   ({d.none, d.sel}),
        .in_valid_i  (bus.in_valid && !d.bad),
        .in_ready_o  (bus.in_ready),
        .out_data_o  ({bus.out_none, bus.out_select}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready)
    );
    always_comb begin
        acc_bad   = bus.in_valid && bus.in_ready && d.bad;
        err_d     = acc_bad ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
        err_idx_d = (acc_bad && (!err_q || bus.err_clr)) ? bus.in_idx :
                    bus.err_clr ? '0 : err_idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end
    assign bus.err     = err_q;
    assign bus.err_idx = err_idx_q;
endmodule
